// File: rtl/sap_pkg.sv
// Shared widths, bus-source encoding and opcode constants for the SAP-style 8-bit CPU.
package sap_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_RAM  = 3'd1,
    SRC_ALU  = 3'd2,
    SRC_A    = 3'd3,
    SRC_IR   = 3'd4,
    SRC_PC   = 3'd5
  } bus_src_e;

  localparam logic [3:0] LDA = 4'h1;
  localparam logic [3:0] ADD = 4'h2;
  localparam logic [3:0] OUT = 4'hE;
  localparam logic [3:0] HLT = 4'hF;

  // Number of bus drivers asserted at once; anything above one is a conflict.
  function automatic logic [2:0] count_drivers(input logic [4:0] drv);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) begin
      n = n + {2'b00, drv[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sap_datapath_ram.sv
// 16x8 program/data RAM: asynchronous read, synchronous write, no reset.
// The write port is shared between the ri bus path and the program-load port.
import sap_pkg::*;

module sap_ram16x8 (
  input  logic              clk,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              ri_we,
  input  logic [ADDR_W-1:0] ri_addr,
  input  logic [DATA_W-1:0] ri_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [16];
  logic              we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [DATA_W-1:0] wdata_s;

  // Select the write source: the load port owns the RAM in program mode.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = {ADDR_W{1'b0}};
    wdata_s = {DATA_W{1'b0}};
    if (prog_mode) begin
      we_s    = prog_we;
      waddr_s = prog_addr;
      wdata_s = prog_data;
    end else begin
      we_s    = ri_we;
      waddr_s = ri_addr;
      wdata_s = ri_data;
    end
  end

  // Synchronous write.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/sap_datapath.sv
// SAP-style 8-bit datapath: executes one decoder control word per rising edge
// around a single prioritised 8-bit bus, with a program-load port for the RAM.
import sap_pkg::*;

module sap_datapath (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt,
  input  logic              mi,
  input  logic              ri,
  input  logic              ro,
  input  logic              io,
  input  logic              ii,
  input  logic              ai,
  input  logic              ao,
  input  logic              sumo,
  input  logic              sub,
  input  logic              bi,
  input  logic              oi,
  input  logic              ce,
  input  logic              co,
  input  logic              j,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] insn,
  output logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] out_val,
  output logic [ADDR_W-1:0] pc,
  output logic              carry,
  output logic              zero,
  output logic              halted,
  output logic              bus_conflict
);

  logic [ADDR_W-1:0] mar_r, pc_r;
  logic [DATA_W-1:0] a_r, b_r, insn_r, out_r;
  logic              carry_r, zero_r, halted_r;
  logic [DATA_W:0]   sum_s;
  logic [DATA_W-1:0] ram_rd_s, bus_s, b_op_s;
  bus_src_e          src_s;
  logic              exec_s;

  // Control word takes effect only outside program mode and before a halt.
  assign exec_s = ~prog_mode & ~halted_r;
  assign b_op_s = sub ? ~b_r : b_r;
  assign sum_s  = {1'b0, a_r} + {1'b0, b_op_s} + {{DATA_W{1'b0}}, sub};

  sap_ram16x8 u_ram (
    .clk       (clk),
    .prog_mode (prog_mode),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .ri_we     (ri & exec_s),
    .ri_addr   (mar_r),
    .ri_data   (bus_s),
    .rd_addr   (mar_r),
    .rd_data   (ram_rd_s)
  );

  // Bus source arbitration: ro > sumo > ao > io > co.
  always_comb begin
    src_s = SRC_NONE;
    if (ro) begin
      src_s = SRC_RAM;
    end else if (sumo) begin
      src_s = SRC_ALU;
    end else if (ao) begin
      src_s = SRC_A;
    end else if (io) begin
      src_s = SRC_IR;
    end else if (co) begin
      src_s = SRC_PC;
    end else begin
      src_s = SRC_NONE;
    end
  end

  // Bus value for the selected source.
  always_comb begin
    bus_s = 8'h00;
    case (src_s)
      SRC_RAM: bus_s = ram_rd_s;
      SRC_ALU: bus_s = sum_s[DATA_W-1:0];
      SRC_A:   bus_s = a_r;
      SRC_IR:  bus_s = {4'h0, insn_r[3:0]};
      SRC_PC:  bus_s = {4'h0, pc_r};
      default: bus_s = 8'h00;
    endcase
  end

  // Sticky halt; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_r <= 1'b0;
    end else if (!prog_mode && hlt) begin
      halted_r <= 1'b1;
    end
  end

  // Register loads from the bus, program counter and ALU flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mar_r   <= 4'h0;
      pc_r    <= 4'h0;
      a_r     <= 8'h00;
      b_r     <= 8'h00;
      insn_r  <= 8'h00;
      out_r   <= 8'h00;
      carry_r <= 1'b0;
      zero_r  <= 1'b0;
    end else if (exec_s) begin
      if (mi) mar_r  <= bus_s[ADDR_W-1:0];
      if (ii) insn_r <= bus_s;
      if (ai) a_r    <= bus_s;
      if (bi) b_r    <= bus_s;
      if (oi) out_r  <= bus_s;
      // A jump overrides the increment when both are asserted.
      if (j) begin
        pc_r <= bus_s[ADDR_W-1:0];
      end else if (ce) begin
        pc_r <= pc_r + 4'd1;
      end
      if (sumo) begin
        carry_r <= sum_s[DATA_W];
        zero_r  <= (sum_s[DATA_W-1:0] == 8'h00);
      end
    end
  end

  assign insn         = insn_r;
  assign bus          = bus_s;
  assign out_val      = out_r;
  assign pc           = pc_r;
  assign carry        = carry_r;
  assign zero         = zero_r;
  assign halted       = halted_r;
  assign bus_conflict = (count_drivers({ro, sumo, ao, io, co}) >= 3'd2);

endmodule

// File: tb/tb_sap_datapath.sv
// Directed self-checking bench for sap_datapath: program load, LDA micro-steps,
// ALU and flags, bus priority/conflict, PC wrap and jump, reset and halt.
module tb_sap_datapath;
  import sap_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j;
  logic prog_mode, prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] insn, bus, out_val;
  logic [3:0] pc;
  logic carry, zero, halted, bus_conflict;

  int errors = 0;
  int checks = 0;

  sap_datapath dut (
    .clk(clk), .rst(rst), .hlt(hlt), .mi(mi), .ri(ri), .ro(ro), .io(io), .ii(ii),
    .ai(ai), .ao(ao), .sumo(sumo), .sub(sub), .bi(bi), .oi(oi), .ce(ce), .co(co),
    .j(j), .prog_mode(prog_mode), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .insn(insn), .bus(bus), .out_val(out_val), .pc(pc),
    .carry(carry), .zero(zero), .halted(halted), .bus_conflict(bus_conflict)
  );

  always #5 clk = ~clk;

  task automatic ctrl_clear();
    {hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j} = 15'h0;
    prog_we = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input logic [3:0] addr, input logic [7:0] data);
    ctrl_clear();
    prog_mode = 1'b1; prog_we = 1'b1; prog_addr = addr; prog_data = data;
    cyc();
    prog_we = 1'b0; prog_mode = 1'b0;
  endtask

  // Loads A or B through RAM[mar]; the bench keeps mar pointed at a scratch word.
  task automatic load_reg(input logic [3:0] scratch, input logic [7:0] v, input logic to_b);
    prog_write(scratch, v);
    ctrl_clear(); ro = 1'b1; ai = ~to_b; bi = to_b;
    cyc();
    ctrl_clear();
  endtask

  task automatic test_load_lda();
    prog_write(4'h0, 8'h1E);
    prog_write(4'hE, 8'h1C);
    // Control inputs must be ignored in program mode.
    ctrl_clear(); prog_mode = 1'b1; ce = 1'b1; j = 1'b1; co = 1'b1;
    cyc();
    prog_mode = 1'b0; ctrl_clear(); #1;
    checks++; if (pc !== 4'h0) begin errors++; $display("FAIL prog_mode_pc_hold: got %h expected %h", pc, 4'h0); end

    co = 1'b1; mi = 1'b1; #1;
    checks++; if (bus !== 8'h00) begin errors++; $display("FAIL fetch_co_bus: got %h expected %h", bus, 8'h00); end
    cyc();
    ctrl_clear(); ro = 1'b1; ii = 1'b1; ce = 1'b1; #1;
    checks++; if (bus !== 8'h1E) begin errors++; $display("FAIL fetch_ram_bus: got %h expected %h", bus, 8'h1E); end
    cyc();
    checks++; if (insn !== 8'h1E) begin errors++; $display("FAIL fetch_insn: got %h expected %h", insn, 8'h1E); end
    checks++; if (pc !== 4'h1) begin errors++; $display("FAIL fetch_pc: got %h expected %h", pc, 4'h1); end
    ctrl_clear(); io = 1'b1; mi = 1'b1; #1;
    checks++; if (bus !== 8'h0E) begin errors++; $display("FAIL lda_io_bus: got %h expected %h", bus, 8'h0E); end
    cyc();
    ctrl_clear(); ro = 1'b1; ai = 1'b1; #1;
    checks++; if (bus !== 8'h1C) begin errors++; $display("FAIL lda_mar14_bus: got %h expected %h", bus, 8'h1C); end
    cyc();
    ctrl_clear(); ao = 1'b1; #1;
    checks++; if (bus !== 8'h1C) begin errors++; $display("FAIL lda_a: got %h expected %h", bus, 8'h1C); end
    // Park mar on address 1 (pc) as scratch for later register loads.
    ctrl_clear(); co = 1'b1; mi = 1'b1;
    cyc();
    ctrl_clear();
  endtask

  task automatic test_alu();
    load_reg(4'h1, 8'hFF, 1'b0);
    load_reg(4'h1, 8'h01, 1'b1);
    sumo = 1'b1; #1;
    checks++; if (bus !== 8'h00) begin errors++; $display("FAIL alu_add_bus: got %h expected %h", bus, 8'h00); end
    ai = 1'b1;
    cyc();
    checks++; if ({carry, zero} !== 2'b11) begin errors++; $display("FAIL alu_add_flags: got %b expected %b", {carry, zero}, 2'b11); end
    ctrl_clear(); ao = 1'b1; #1;
    checks++; if (bus !== 8'h00) begin errors++; $display("FAIL alu_add_a: got %h expected %h", bus, 8'h00); end
    load_reg(4'h1, 8'h05, 1'b0);
    load_reg(4'h1, 8'h07, 1'b1);
    checks++; if ({carry, zero} !== 2'b11) begin errors++; $display("FAIL flags_hold: got %b expected %b", {carry, zero}, 2'b11); end
    sub = 1'b1; sumo = 1'b1; #1;
    checks++; if (bus !== 8'hFE) begin errors++; $display("FAIL alu_sub_bus: got %h expected %h", bus, 8'hFE); end
    ai = 1'b1;
    cyc();
    checks++; if ({carry, zero} !== 2'b00) begin errors++; $display("FAIL alu_sub_flags: got %b expected %b", {carry, zero}, 2'b00); end
    ctrl_clear(); ao = 1'b1; #1;
    checks++; if (bus !== 8'hFE) begin errors++; $display("FAIL alu_sub_a: got %h expected %h", bus, 8'hFE); end
    ctrl_clear();
  endtask

  task automatic test_bus_conflict();
    load_reg(4'h1, 8'h33, 1'b0);
    prog_write(4'h1, 8'h44);
    ro = 1'b1; ao = 1'b1; #1;
    checks++; if (bus !== 8'h44) begin errors++; $display("FAIL conflict_bus: got %h expected %h", bus, 8'h44); end
    checks++; if (bus_conflict !== 1'b1) begin errors++; $display("FAIL conflict_flag: got %b expected %b", bus_conflict, 1'b1); end
    ai = 1'b1;
    cyc();
    ctrl_clear(); ao = 1'b1; #1;
    checks++; if (bus !== 8'h44) begin errors++; $display("FAIL conflict_a_load: got %h expected %h", bus, 8'h44); end
    checks++; if (bus_conflict !== 1'b0) begin errors++; $display("FAIL single_driver_flag: got %b expected %b", bus_conflict, 1'b0); end
    // ao outranks io and co.
    io = 1'b1; co = 1'b1; #1;
    checks++; if (bus !== 8'h44) begin errors++; $display("FAIL prio_ao_io_co: got %h expected %h", bus, 8'h44); end
    ctrl_clear(); io = 1'b1; co = 1'b1; #1;
    checks++; if (bus !== 8'h0E) begin errors++; $display("FAIL prio_io_co: got %h expected %h", bus, 8'h0E); end
    ctrl_clear(); #1;
    checks++; if (bus !== 8'h00) begin errors++; $display("FAIL no_driver_bus: got %h expected %h", bus, 8'h00); end
  endtask

  task automatic test_pc();
    load_reg(4'h1, 8'h0F, 1'b0);
    ao = 1'b1; j = 1'b1;
    cyc();
    checks++; if (pc !== 4'hF) begin errors++; $display("FAIL pc_jump15: got %h expected %h", pc, 4'hF); end
    ctrl_clear(); ce = 1'b1;
    cyc();
    checks++; if (pc !== 4'h0) begin errors++; $display("FAIL pc_wrap: got %h expected %h", pc, 4'h0); end
    load_reg(4'h1, 8'h07, 1'b0);
    ao = 1'b1; j = 1'b1; ce = 1'b1;
    cyc();
    checks++; if (pc !== 4'h7) begin errors++; $display("FAIL pc_j_over_ce: got %h expected %h", pc, 4'h7); end
    ctrl_clear(); ao = 1'b1; oi = 1'b1;
    cyc();
    checks++; if (out_val !== 8'h07) begin errors++; $display("FAIL out_load: got %h expected %h", out_val, 8'h07); end
    ctrl_clear();
  endtask

  task automatic test_reset();
    // Assert reset between edges with an in-flight load pending.
    ao = 1'b1; oi = 1'b1; ce = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (pc !== 4'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 4'h0); end
    checks++; if (out_val !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected %h", out_val, 8'h00); end
    checks++; if (insn !== 8'h00) begin errors++; $display("FAIL reset_insn: got %h expected %h", insn, 8'h00); end
    checks++; if ({halted, carry, zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected %b", {halted, carry, zero}, 3'b000); end
    cyc();
    rst = 1'b0; ctrl_clear(); #1;
    checks++; if (bus !== 8'h00) begin errors++; $display("FAIL reset_bus_idle: got %h expected %h", bus, 8'h00); end
    ao = 1'b1; #1;
    checks++; if (bus !== 8'h00) begin errors++; $display("FAIL reset_a: got %h expected %h", bus, 8'h00); end
    ctrl_clear();
  endtask

  task automatic test_halt();
    prog_write(4'h0, 8'h55);
    hlt = 1'b1;
    cyc();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected %b", halted, 1'b1); end
    ctrl_clear(); ro = 1'b1; ai = 1'b1; ce = 1'b1; #1;
    checks++; if (bus !== 8'h55) begin errors++; $display("FAIL halt_bus_live: got %h expected %h", bus, 8'h55); end
    cyc();
    ctrl_clear(); ao = 1'b1; #1;
    checks++; if (bus !== 8'h00) begin errors++; $display("FAIL halt_a_hold: got %h expected %h", bus, 8'h00); end
    checks++; if (pc !== 4'h0) begin errors++; $display("FAIL halt_pc_hold: got %h expected %h", pc, 4'h0); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b expected %b", halted, 1'b1); end
    ctrl_clear(); #2 rst = 1'b1; #2 rst = 1'b0; #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_cleared: got %b expected %b", halted, 1'b0); end
    // RAM survives reset: point mar at 14 through RAM[0] and read back.
    prog_write(4'h0, 8'h0E);
    ro = 1'b1; mi = 1'b1;
    cyc();
    ctrl_clear(); ro = 1'b1; #1;
    checks++; if (bus !== 8'h1C) begin errors++; $display("FAIL ram_survives_reset: got %h expected %h", bus, 8'h1C); end
    // Write-then-read of the same address on the next cycle.
    ctrl_clear(); co = 1'b1; ri = 1'b1;
    cyc();
    ctrl_clear(); ro = 1'b1; #1;
    checks++; if (bus !== 8'h00) begin errors++; $display("FAIL ram_write_read: got %h expected %h", bus, 8'h00); end
    ctrl_clear();
  endtask

  initial begin
    rst = 1'b1; prog_mode = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
    ctrl_clear();
    #12 rst = 1'b0;
    cyc();
    test_load_lda();
    test_alu();
    test_bus_conflict();
    test_pc();
    test_reset();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sap_datapath.md
# sap_datapath

Register/bus/memory datapath of the SAP-style 8-bit CPU: executes, one clock at a time, the control word emitted by the microcode decoder. Holds the program counter, memory address register, 16×8 RAM, instruction register, A/B registers, ALU, flags and output register around a single 8-bit bus. Returns the instruction register to the decoder. Includes a program-load port used while the decoder is held in program mode.

## Interface
- No parameters; widths are fixed by the shared package (data 8, address 4).
- clk  in  1  datapath clock; all registers update on the rising edge, while the decoder updates on the falling edge.
- rst  in  1  reset, asynchronous, active-high.
- hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j  in  1 each  control word from the decoder.
- prog_mode  in  1  program-load mode; when high, all control inputs are ignored.
- prog_we  in  1  RAM write strobe, effective only in program mode.
- prog_addr  in  4  RAM address for program load.
- prog_data  in  8  RAM data for program load.
- insn  out  8  instruction register, fed to the decoder.
- bus  out  8  current bus value (combinational).
- out_val  out  8  output register.
- pc  out  4  program counter.
- carry, zero  out  1 each  ALU flags.
- halted  out  1  sticky halt flag.
- bus_conflict  out  1  high while more than one bus driver is asserted (combinational).

## Operation
- **Bus drivers**
  - Sources: ro → RAM[mar]; sumo → ALU result; ao → A; io → {4'h0, insn[3:0]}; co → {4'h0, pc}.
  - Priority when several are asserted: ro > sumo > ao > io > co.
  - No driver asserted → bus = 8'h00.
  - bus_conflict = 1 whenever two or more drivers are asserted.
- **Loads (rising edge, from current bus)**
  - mi: mar ← bus[3:0].
  - ri: RAM[mar] ← bus.
  - ii: insn ← bus.
  - ai: A ← bus.
  - bi: B ← bus.
  - oi: out_val ← bus.
  - j: pc ← bus[3:0].
- **Program counter**
  - ce alone: pc ← pc+1 modulo 16, so 15 wraps to 0.
  - j and ce together: j wins.
- **ALU** (combinational from the A/B registers)
  - 9-bit result = A + (sub ? ~B : B) + sub.
  - The ALU result output is bits [7:0].
  - On a rising edge with sumo high: carry ← bit 8, zero ← (bits [7:0] == 0).
  - Flags hold otherwise.
- **Halt**
  - hlt sampled high sets halted.
  - halted clears only on rst.
  - While halted, all register, flag and RAM writes from the control word are suppressed; the bus remains combinational.
- **Program mode**
  - prog_we high: RAM[prog_addr] ← prog_data.
  - All other state holds.
  - hlt input is ignored.
- **Reset**
  - pc, mar, A, B, insn, out_val, carry, zero and halted all clear to 0.
  - RAM is NOT cleared, so a loaded program survives reset.
  - Reset mid-instruction discards any in-flight load.

## Timing
- Bus, ALU result and bus_conflict are combinational from control inputs and registers; no added latency.
- Each load completes at the first rising edge where its control bit is high, i.e. half a cycle after the decoder's falling-edge update.
- Same-edge hazards:
  - ai with sumo: A receives the sum of the old A/B.
  - ro with ri: RAM rewrites its old value.
  - ii with io: insn receives the bus value formed from the old insn.
- RAM read is asynchronous and write is synchronous.
- A write followed by a read of the same address on the next cycle returns the new data.

## Structure
- Package sap_pkg holds:
  - DATA_W = 8 and ADDR_W = 4.
  - An enum of bus sources (NONE, RAM, ALU, A, IR, PC).
  - Opcode constants: LDA = 4'h1, ADD = 4'h2, OUT = 4'hE, HLT = 4'hF.
- Sub-module sap_ram16x8:
  - Asynchronous read; synchronous write.
  - Write port multiplexed between the ri path and the program-load path.
  - No reset.

## Test plan
- **Reset:** pulse rst with registers nonzero → pc = 0, out_val = 0, insn = 0, halted = 0, carry = zero = 0; bus = 8'h00 with no drivers.
- **Load and LDA:**
  - Stimulus: in program mode write RAM[0] = 8'h1E and RAM[14] = 8'h1C; leave program mode; drive the fetch and execute micro-steps.
  - co+mi → mar = 0.
  - ro+ii+ce → insn = 8'h1E, pc = 1.
  - io+mi → mar = 14.
  - ro+ai → A = 8'h1C.
- **ALU:**
  - A = 8'hFF, B = 8'h01, sumo+ai → A = 8'h00, carry = 1, zero = 1.
  - A = 8'h05, B = 8'h07, sub+sumo+ai → A = 8'hFE, carry = 0, zero = 0.
- **Bus conflict:** A = 8'h33, RAM[mar] = 8'h44, ro+ao together → bus = 8'h44, bus_conflict = 1; ai loads 8'h44.
- **PC:**
  - pc = 15, ce → pc = 0.
  - ce+j with A = 8'h07 driven by ao → pc = 7.
- **Halt:**
  - hlt, then ai with ao/bus = 8'h55 → A unchanged, halted = 1.
  - rst → halted = 0, RAM[14] still 8'h1C.
